vga_capture_receiver: RTL

//  Receiving end of our VGA link: decodes HSync/VSync/RGB as sent by the VGA controller and locks to 640x480 timing.

---
 rtl/vga_timing_pkg.sv | 39 +++
 rtl/vga_sync_tracker.sv | 80 ++++++++
 rtl/vga_capture_receiver.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_timing_pkg : shared 640x480 timing, capture window, rx FSM    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package vga_timing_pkg;

   localparam int H_SYNC   = 96;
   localparam int H_BACK   = 48;
   localparam int H_ACTIVE = 640;
   localparam int H_FRONT  = 16;
   localparam int H_TOTAL  = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;

   localparam int V_SYNC   = 2;
   localparam int V_BACK   = 29;
   localparam int V_ACTIVE = 480;
   localparam int V_FRONT  = 10;
   localparam int V_TOTAL  = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

   localparam int H_ACT_OFS = H_SYNC + H_BACK;
   localparam int V_ACT_OFS = V_SYNC + V_BACK;

   localparam int WIN_X       = 192;
   localparam int WIN_Y       = 112;
   localparam int WIN_SIZE    = 256;
   localparam int LOCK_FRAMES = 2;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_ALIGN  = 2'd1,
      ST_LOCKED = 2'd2
   } rx_state_t;

   function automatic logic [9:0] sat_inc10(input logic [9:0] v);
      return (v == 10'h3FF) ? v : v + 10'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_tracker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_sync_tracker : pixel strobe, sync edges, column/row, errors   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module vga_sync_tracker #(
   parameter int H_TOTAL = vga_timing_pkg::H_TOTAL,
   parameter int V_TOTAL = vga_timing_pkg::V_TOTAL
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_hsync,
   input  logic       i_vsync,
   output logic       o_strobe,
   output logic [9:0] o_col,
   output logic [9:0] o_row,
   output logic [9:0] o_col_nxt,
   output logic [9:0] o_row_nxt,
   output logic       o_frame_start,
   output logic       o_line_err,
   output logic       o_frame_err
);
   import vga_timing_pkg::*;

   localparam logic [9:0] c_H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] c_V_LAST = 10'(V_TOTAL - 1);

   logic       r_strobe;
   logic       r_hs_prev;
   logic       r_vs_prev;
   logic       r_vpend;
   logic [9:0] r_col;
   logic [9:0] r_row;
   logic       w_hfall;
   logic       w_vfall;
   logic       w_fstart;
   logic [9:0] w_col_nxt;
   logic [9:0] w_row_nxt;

   assign w_hfall   = r_strobe & r_hs_prev & ~i_hsync;
   assign w_vfall   = r_strobe & r_vs_prev & ~i_vsync;
   // A VSync fall arms the frame start; the line that follows it is row 0.
   assign w_fstart  = w_hfall & (r_vpend | w_vfall);
   assign w_col_nxt = w_hfall ? 10'd0 : sat_inc10(r_col);
   assign w_row_nxt = w_fstart ? 10'd0 : (w_hfall ? sat_inc10(r_row) : r_row);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_strobe  <= 1'b0;
         r_hs_prev <= 1'b1;
         r_vs_prev <= 1'b1;
         r_vpend   <= 1'b0;
         r_col     <= 10'd0;
         r_row     <= 10'd0;
      end else begin
         r_strobe <= ~r_strobe;
         if (r_strobe) begin
            r_hs_prev <= i_hsync;
            r_vs_prev <= i_vsync;
            r_col     <= w_col_nxt;
            r_row     <= w_row_nxt;
            if (w_fstart)
               r_vpend <= 1'b0;
            else if (w_vfall)
               r_vpend <= 1'b1;
         end
      end
   end

   assign o_strobe      = r_strobe;
   assign o_col         = r_col;
   assign o_row         = r_row;
   assign o_col_nxt     = w_col_nxt;
   assign o_row_nxt     = w_row_nxt;
   assign o_frame_start = w_fstart;
   assign o_line_err    = w_hfall & (r_col != c_H_LAST);
   assign o_frame_err   = w_fstart & (r_row != c_V_LAST);

endmodule
`default_nettype wire

// File: rtl/vga_capture_receiver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_capture_receiver : lock to VGA timing, write window to RAM    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module vga_capture_receiver #(
   parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
   parameter int H_BACK      = vga_timing_pkg::H_BACK,
   parameter int H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
   parameter int H_FRONT     = vga_timing_pkg::H_FRONT,
   parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
   parameter int V_BACK      = vga_timing_pkg::V_BACK,
   parameter int V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
   parameter int V_FRONT     = vga_timing_pkg::V_FRONT,
   parameter int WIN_X       = vga_timing_pkg::WIN_X,
   parameter int WIN_Y       = vga_timing_pkg::WIN_Y,
   parameter int WIN_W       = vga_timing_pkg::WIN_SIZE,
   parameter int WIN_H       = vga_timing_pkg::WIN_SIZE,
   parameter int LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        iHSync,
   input  logic        iVSync,
   input  logic        iVGA_Red,
   input  logic        iVGA_Green,
   input  logic        iVGA_Blue,
   output logic [15:0] oWriteAddress,
   output logic [2:0]  oWriteData,
   output logic        oWriteEnable,
   output logic [9:0]  oColumn,
   output logic [9:0]  oRow,
   output logic        oLocked,
   output logic        oSyncError,
   output logic        oFrameDone
);
   import vga_timing_pkg::*;

   localparam logic [9:0] c_COL0    = 10'(H_SYNC + H_BACK + WIN_X);
   localparam logic [9:0] c_COL_END = 10'(H_SYNC + H_BACK + WIN_X + WIN_W);
   localparam logic [9:0] c_ROW0    = 10'(V_SYNC + V_BACK + WIN_Y);
   localparam logic [9:0] c_ROW_END = 10'(V_SYNC + V_BACK + WIN_Y + WIN_H);
   localparam logic [7:0] c_X_LAST  = 8'(WIN_W - 1);
   localparam logic [7:0] c_Y_LAST  = 8'(WIN_H - 1);
   localparam logic [3:0] c_LOCK    = 4'(LOCK_FRAMES);

   rx_state_t   r_state;
   logic [3:0]  r_good;
   logic        r_locked;
   logic        r_sync_err;
   logic        r_we;
   logic        r_fd;
   logic [15:0] r_addr;
   logic [2:0]  r_data;

   logic        w_strobe;
   logic [9:0]  w_col;
   logic [9:0]  w_row;
   logic [9:0]  w_col_nxt;
   logic [9:0]  w_row_nxt;
   logic        w_fstart;
   logic        w_line_err;
   logic        w_frame_err;
   logic        w_err;
   logic        w_hit;
   logic        w_write;
   logic [7:0]  w_xw;
   logic [7:0]  w_yw;

   vga_sync_tracker #(
      .H_TOTAL (H_SYNC + H_BACK + H_ACTIVE + H_FRONT),
      .V_TOTAL (V_SYNC + V_BACK + V_ACTIVE + V_FRONT)
   ) u_tracker (
      .clk           (Clock),
      .rst           (Reset),
      .i_hsync       (iHSync),
      .i_vsync       (iVSync),
      .o_strobe      (w_strobe),
      .o_col         (w_col),
      .o_row         (w_row),
      .o_col_nxt     (w_col_nxt),
      .o_row_nxt     (w_row_nxt),
      .o_frame_start (w_fstart),
      .o_line_err    (w_line_err),
      .o_frame_err   (w_frame_err)
   );

   assign w_err = w_line_err | w_frame_err;
   // Window offsets fit in 8 bits, so the low-byte difference is exact.
   assign w_xw  = w_col_nxt[7:0] - c_COL0[7:0];
   assign w_yw  = w_row_nxt[7:0] - c_ROW0[7:0];
   assign w_hit = (w_col_nxt >= c_COL0) && (w_col_nxt < c_COL_END) &&
                  (w_row_nxt >= c_ROW0) && (w_row_nxt < c_ROW_END);
   assign w_write = w_strobe & w_hit & (r_state == ST_LOCKED) & ~w_err;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state    <= ST_SEARCH;
         r_good     <= 4'd0;
         r_locked   <= 1'b0;
         r_sync_err <= 1'b0;
      end else begin
         r_sync_err <= 1'b0;
         if (w_strobe) begin
            case (r_state)
               ST_SEARCH: begin
                  if (w_fstart) begin
                     r_state <= ST_ALIGN;
                     r_good  <= 4'd0;
                  end
               end
               ST_ALIGN, ST_LOCKED: begin
                  if (w_err) begin
                     r_state    <= ST_SEARCH;
                     r_locked   <= 1'b0;
                     r_sync_err <= 1'b1;
                  end else if ((r_state == ST_ALIGN) && w_fstart) begin
                     r_good <= r_good + 4'd1;
                     if (r_good + 4'd1 == c_LOCK) begin
                        r_state  <= ST_LOCKED;
                        r_locked <= 1'b1;
                     end
                  end
               end
               default: begin
                  r_state  <= ST_SEARCH;
                  r_locked <= 1'b0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_we   <= 1'b0;
         r_fd   <= 1'b0;
         r_addr <= 16'd0;
         r_data <= 3'd0;
      end else begin
         r_we <= w_write;
         r_fd <= w_write & (w_xw == c_X_LAST) & (w_yw == c_Y_LAST);
         if (w_write) begin
            r_addr <= {w_yw, w_xw};
            r_data <= {iVGA_Red, iVGA_Green, iVGA_Blue};
         end
      end
   end

   assign oWriteAddress = r_addr;
   assign oWriteData    = r_data;
   assign oWriteEnable  = r_we;
   assign oColumn       = w_col;
   assign oRow          = w_row;
   assign oLocked       = r_locked;
   assign oSyncError    = r_sync_err;
   assign oFrameDone    = r_fd;

endmodule
`default_nettype wire
